// File: rtl/pipe_pkg.sv
// Shared definitions for the control pipeline: packed control-word layout,
// the NOP/bubble word and symbolic stage indices.
package pipe_pkg;

  // Control-word field widths (total 16 bits).
  localparam int ALU_OP_W     = 4;
  localparam int SHIFT_AM_W   = 4;
  localparam int S_W          = 1;
  localparam int LOAD_W       = 1;
  localparam int RF_ENABLE_W  = 1;
  localparam int B_W          = 1;
  localparam int BL_W         = 1;
  localparam int SIZE_W       = 2;
  localparam int LOAD_STORE_W = 1;

  // Control-word field offsets, LSB first.
  localparam int LOAD_STORE_OFS = 0;
  localparam int SIZE_OFS       = LOAD_STORE_OFS + LOAD_STORE_W;
  localparam int BL_OFS         = SIZE_OFS + SIZE_W;
  localparam int B_OFS          = BL_OFS + BL_W;
  localparam int RF_ENABLE_OFS  = B_OFS + B_W;
  localparam int LOAD_OFS       = RF_ENABLE_OFS + RF_ENABLE_W;
  localparam int S_OFS          = LOAD_OFS + LOAD_W;
  localparam int SHIFT_AM_OFS   = S_OFS + S_W;
  localparam int ALU_OP_OFS     = SHIFT_AM_OFS + SHIFT_AM_W;
  localparam int CTRL_W         = ALU_OP_OFS + ALU_OP_W;

  typedef struct packed {
    logic [ALU_OP_W-1:0]   alu_op;
    logic [SHIFT_AM_W-1:0] shift_am;
    logic                  s;
    logic                  load;
    logic                  rf_enable;
    logic                  b;
    logic                  bl;
    logic [SIZE_W-1:0]     size;
    logic                  load_store;
  } ctrl_word_t;

  // A bubble does nothing: no register write, no memory access, no branch.
  localparam logic [CTRL_W-1:0] NOP_WORD = '0;

  // Stage indices of the classic four-stage arrangement.
  localparam int ID  = 0;
  localparam int EX  = 1;
  localparam int MEM = 2;
  localparam int WB  = 3;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_word_t c);
    return c;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+payload pipeline register. Priority: reset, flush, hold,
// bubble insertion, then load of the previous entry. An invalid entry
// always carries the BUBBLE payload.
module pipe_stage_reg #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             bubble_sel,
  input  logic             hold,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Stage register update following the priority list.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
      data  <= BUBBLE;
    end else if (!hold) begin
      if (bubble_sel || !prev_valid) begin
        valid <= 1'b0;
        data  <= BUBBLE;
      end else begin
        valid <= 1'b1;
        data  <= prev_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised DEPTH-stage control pipeline with per-stage hold (stall
// propagating upstream), bubble insertion below the hold boundary and
// per-stage flush. Optional performance counters are built when the macro
// PIPE_PERF_CNT_EN is defined.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 16,
  parameter int               DEPTH  = 4,   // legal range 2..8
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_WORD)
`ifdef PIPE_PERF_CNT_EN
  , parameter int             CNT_W  = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [DEPTH-1:0]       hold,
  input  logic [DEPTH-1:0]       flush,
  output logic                   in_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]       retire_cnt
`endif
);

  // Effective hold: a stall at stage k freezes every stage at or below k.
  logic [DEPTH-1:0] eh;
  logic [WIDTH-1:0] stg_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign eh[i] = |(hold >> i);
    assign stage_data[i*WIDTH +: WIDTH] = stg_data[i];

    if (i == 0) begin : g_first
      pipe_stage_reg #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_reg (
        .clk        (clk),
        .reset      (reset),
        .prev_valid (in_valid),
        .prev_data  (in_data),
        .bubble_sel (1'b0),
        .hold       (eh[0]),
        .flush      (flush[0]),
        .valid      (stage_valid[0]),
        .data       (stg_data[0])
      );
    end else begin : g_next
      // eh[i-1] without eh[i] means the hold boundary sits right above us.
      pipe_stage_reg #(.WIDTH(WIDTH), .BUBBLE(BUBBLE)) u_reg (
        .clk        (clk),
        .reset      (reset),
        .prev_valid (stage_valid[i-1]),
        .prev_data  (stg_data[i-1]),
        .bubble_sel (eh[i-1]),
        .hold       (eh[i]),
        .flush      (flush[i]),
        .valid      (stage_valid[i]),
        .data       (stg_data[i])
      );
    end
  end

  assign in_ready  = ~eh[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stall and retire counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (|hold)
        stall_cnt <= sat_inc(stall_cnt);
      if (stage_valid[DEPTH-1] && !hold[DEPTH-1] && !flush[DEPTH-1])
        retire_cnt <= sat_inc(retire_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=4, WIDTH=16, non-zero bubble).
module tb_pipe_stage_chain;

  localparam int               W   = 16;
  localparam int               D   = 4;
  localparam logic [W-1:0]     BUB = 16'hF00D;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic [D-1:0]     hold;
  logic [D-1:0]     flush;
  logic             in_ready;
  logic [D-1:0]     stage_valid;
  logic [D*W-1:0]   stage_data;
  logic             out_valid;
  logic [W-1:0]     out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0]    stall_cnt, retire_cnt;
  logic [D-1:0]   hold_s;
  logic           s_ready, s_ov;
  logic [D-1:0]   s_sv;
  logic [D*W-1:0] s_sd;
  logic [W-1:0]   s_od;
  logic [3:0]     s_stall, s_retire;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .hold(hold), .flush(flush), .in_ready(in_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(1'b0), .in_data(16'h0000),
    .hold(hold_s), .flush(4'b0000), .in_ready(s_ready),
    .stage_valid(s_sv), .stage_data(s_sd),
    .out_valid(s_ov), .out_data(s_od),
    .stall_cnt(s_stall), .retire_cnt(s_retire));
`else
  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .BUBBLE(BUB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .hold(hold), .flush(flush), .in_ready(in_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data));
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input logic [W-1:0] s3, input logic [W-1:0] s2,
                                        input logic [W-1:0] s1, input logic [W-1:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; hold = '0; flush = '0;
`ifdef PIPE_PERF_CNT_EN
    hold_s = '0;
`endif
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_stage_valid", 64'(stage_valid), 64'h0);
    chk("rst_stage_data", stage_data, pack4(BUB, BUB, BUB, BUB));
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'(BUB));
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Streaming: 1..4 presented on cycles 1..4, visible on out after 4..7
    for (int k = 1; k <= 9; k++) begin
      in_valid = (k <= 4);
      in_data  = (k <= 4) ? W'(k) : '0;
      step();
      if (k == 1)
        chk("stream_stage0", stage_data, pack4(BUB, BUB, BUB, 16'd1));
      chk($sformatf("stream_ov_%0d", k), 64'(out_valid), 64'((k >= 4 && k <= 7) ? 1 : 0));
      chk($sformatf("stream_od_%0d", k), 64'(out_data),
          64'((k >= 4 && k <= 7) ? W'(k - 3) : BUB));
    end

    // Stall: hold[1] for two cycles while 1..4 stream in
    in_valid = 1'b1; in_data = 16'd1; step();
    in_data = 16'd2; step();
    in_data = 16'd3; hold = 4'b0010; #1;
    chk("stall_in_ready", 64'(in_ready), 64'h0);
    step();
    chk("stall_c3_valid", 64'(stage_valid), 64'h3);
    chk("stall_c3_data", stage_data, pack4(BUB, BUB, 16'd1, 16'd2));
    step();
    chk("stall_c4_valid", 64'(stage_valid), 64'h3);
    chk("stall_c4_data", stage_data, pack4(BUB, BUB, 16'd1, 16'd2));
    hold = 4'b0000; #1;
    chk("stall_release_ready", 64'(in_ready), 64'h1);
    step();
    chk("stall_c5_ov", 64'(out_valid), 64'h0);
    chk("stall_c5_data", stage_data, pack4(BUB, 16'd1, 16'd2, 16'd3));
    in_data = 16'd4; step();
    chk("stall_c6_od", 64'(out_data), 64'd1);
    in_valid = 1'b0; in_data = '0; step();
    chk("stall_c7_od", 64'(out_data), 64'd2);
    step();
    chk("stall_c8_od", 64'(out_data), 64'd3);
    step();
    chk("stall_c9_od", 64'(out_data), 64'd4);
    chk("stall_c9_ov", 64'(out_valid), 64'h1);
    step();
    chk("stall_c10_ov", 64'(out_valid), 64'h0);
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd2);
    chk("retire_cnt", 64'(retire_cnt), 64'd8);
`endif

    // Flush vs hold: flush[2] with hold[3] and stage 2 valid
    in_valid = 1'b1; in_data = 16'd5; step();
    in_data = 16'd6; step();
    in_data = 16'd7; step();
    chk("fh_pre", 64'(stage_valid), 64'h7);
    in_valid = 1'b0; in_data = '0; hold = 4'b1000; flush = 4'b0100; step();
    chk("fh_c4_valid", 64'(stage_valid), 64'h3);
    chk("fh_c4_data", stage_data, pack4(BUB, BUB, 16'd6, 16'd7));
    flush = 4'b0000; step();
    chk("fh_c5_valid", 64'(stage_valid), 64'h3);
    chk("fh_c5_data", stage_data, pack4(BUB, BUB, 16'd6, 16'd7));
    chk("fh_c5_ready", 64'(in_ready), 64'h0);
    hold = 4'b0000; step();
    chk("fh_c6_data", stage_data, pack4(BUB, 16'd6, 16'd7, BUB));
    step();
    chk("fh_c7_od", 64'(out_data), 64'd6);
    step();
    chk("fh_c8_od", 64'(out_data), 64'd7);
    step();
    chk("fh_c9_ov", 64'(out_valid), 64'h0);

    // Flush vs load: flush[0] drops the incoming entry
    in_valid = 1'b1; in_data = 16'h00AA; flush = 4'b0001; #1;
    chk("fl_ready", 64'(in_ready), 64'h1);
    step();
    chk("fl_valid", 64'(stage_valid), 64'h0);
    chk("fl_data", stage_data, pack4(BUB, BUB, BUB, BUB));
    in_valid = 1'b0; in_data = '0; flush = 4'b0000; step();
    chk("fl_dropped", 64'(stage_valid), 64'h0);

    // Reset mid-stream with hold[2]
    in_valid = 1'b1; in_data = 16'd8; step();
    in_data = 16'd9; step();
    in_data = 16'd10; hold = 4'b0100; reset = 1'b1; step();
    chk("mr_valid", 64'(stage_valid), 64'h0);
    chk("mr_data", stage_data, pack4(BUB, BUB, BUB, BUB));
`ifdef PIPE_PERF_CNT_EN
    chk("mr_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("mr_retire_cnt", 64'(retire_cnt), 64'd0);
`endif
    reset = 1'b0; hold = 4'b0000; in_data = 16'd11; step();
    in_valid = 1'b0; in_data = '0; step();
    step();
    chk("mr_lat_early", 64'(out_valid), 64'h0);
    step();
    chk("mr_lat_ov", 64'(out_valid), 64'h1);
    chk("mr_lat_od", 64'(out_data), 64'd11);

`ifdef PIPE_PERF_CNT_EN
    // Saturation of a 4-bit stall counter
    hold_s = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) chk("sat_14", 64'(s_stall), 64'd14);
    end
    chk("sat_20", 64'(s_stall), 64'd15);
    hold_s = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
